fnd_controller: RTL and testbench
=================================

FND_CONTROLLER -- requirements
Module: fnd_controller

Interface
REQ-001 Parameter: CLK_HZ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter: SCAN_HZ, 1000, digit-scan rate in Hz (per digit step).
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: msec  input  7  hundredths value from the stopwatch datapath, valid range 0..99.
REQ-006 Port: sec  input  7  seconds value, valid range 0..59.
REQ-007 Port: min  input  7  minutes value, valid range 0..59.
REQ-008 Port: hour  input  7  hours value, valid range 0..23.
REQ-009 Port: mode  input  1  0 = show sec:msec, 1 = show hour:min.
REQ-010 Port: blank  input  1  1 = all digits dark.
REQ-011 Port: fnd_comm  output  4  digit enables, active-low, one-hot-low; bit 0 = rightmost digit.
REQ-012 Port: fnd_font  output  8  segments, active-low; bit 7 = dp, bits 6..0 = g..a.

Function
REQ-013 Scan divider SHALL count 0..SCAN_DIV-1 (SCAN_DIV = CLK_HZ/SCAN_HZ) and assert a one-cycle scan_tick when count = SCAN_DIV-1, then wrap to 0.
REQ-014 2-bit digit_sel SHALL increment on scan_tick, wrapping 3 -> 0; it is otherwise held.
REQ-015 Frame latch: on the scan_tick where digit_sel wraps 3 -> 0, msec, sec, min, hour and mode SHALL be captured into shadow registers; display uses only shadow values (no tearing within a frame).
REQ-016 Mode 0 digit map: d3 = sec tens, d2 = sec ones, d1 = msec tens, d0 = msec ones; mode 1: d3 = hour tens, d2 = hour ones, d1 = min tens, d0 = min ones.
REQ-017 Tens/ones split SHALL be value/10 and value%10 on 7-bit operands.
REQ-018 A shadow value > 99 SHALL display dash (font 8'hBF) on both of its digits.
REQ-019 Font (dp off): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex).
REQ-020 dp (bit 7 = 0) SHALL be lit only on digit 2 and only when shadow msec < 50, in both modes; otherwise bit 7 = 1.
REQ-021 fnd_comm and fnd_font SHALL be registered: one clock after digit_sel changes, outputs reflect the new digit.
REQ-022 blank = 1 SHALL force fnd_comm = 4'b1111 and fnd_font = 8'hFF on the next clock; counters and shadows keep running.
REQ-023 A mode change mid-frame SHALL take effect only at the next frame latch.

Reset
REQ-024 While reset_n = 0: scan counter = 0, digit_sel = 0, shadows = 0, fnd_comm = 4'b1111, fnd_font = 8'hFF.
REQ-025 First clock edge after reset_n release SHALL drive fnd_comm = 4'b1110, fnd_font = 8'hC0 (digit 0, value 0, dp off since bit 7 belongs to digit 2 only).
REQ-026 Reset asserted mid-frame SHALL immediately return all state to REQ-024 values.

Structure
REQ-027 Shared package SHALL hold the font constants (digits 0..9, dash, blank) and the SCAN_DIV derivation.
REQ-028 One sub-module fnd_decoder (combinational: 4-bit digit code in, 7-bit active-low segments out, codes 10 = dash, 11..15 = blank) SHALL be instantiated once.

Verification (CLK_HZ = 1000, SCAN_HZ = 100, SCAN_DIV = 10)
REQ-029 Reset then release with all inputs 0 -> fnd_comm steps 1110, 1101, 1011, 0111 every 10 clocks; fnd_font = C0 on digits 0,1,3 and 40 on digit 2 (msec 0 < 50, dp lit).
REQ-030 mode=0, sec=42, msec=75 held across a frame latch -> next frame fonts d3=99, d2=A4, d1=F8, d0=92; dp off.
REQ-031 mode=1, hour=23, min=5, msec=10 -> next frame d3=A4, d2=30 (3 with dp), d1=C0, d0=92.
REQ-032 msec=120, mode=0 -> d1 and d0 = BF; change msec mid-frame -> no change until next 3 -> 0 wrap.
REQ-033 blank pulsed 1 for 3 clocks mid-digit -> fnd_comm = 1111 / fnd_font = FF for exactly those 3 clocks (1-cycle delayed); scan phase unaffected.
REQ-034 reset_n dropped during digit 2 -> outputs 1111/FF same cycle; after release scan restarts at digit 0 with shadows 0.

Source files
------------

// File: rtl/fnd_controller_pkg.sv
// -----------------------------------------------------------------------------
// fnd_controller_pkg
// Shared definitions for the 4-digit seven-segment (FND) display controller:
//   - active-low font constants (dp off) for digits 0..9, dash and blank
//   - decoder code points for dash and blank
//   - scan divider derivation from the clock and scan rates
//   - the shadow frame structure latched once per scan frame
//   - tens/ones split helpers on 7-bit operands
// -----------------------------------------------------------------------------
package fnd_controller_pkg;

  // Font bytes are {dp, g, f, e, d, c, b, a}, all active-low.
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Decoder code points above the decimal digits.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  // Largest value that still has a two-digit decimal representation.
  localparam logic [6:0] MAX_SHOWN  = 7'd99;
  // The decimal point marks the first half of every second.
  localparam logic [6:0] DP_LIMIT   = 7'd50;

  // Number of system clocks per digit step.
  function automatic int unsigned scan_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Values captured at the start of each frame so one frame never mixes
  // digits from two different input samples.
  typedef struct packed {
    logic [6:0] msec;
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hour;
    logic       mode;
  } frame_t;

  // Callers only pass values <= 99, so the quotient and remainder fit 4 bits.
  function automatic logic [3:0] split_tens(input logic [6:0] value);
    return 4'(value / 7'd10);
  endfunction

  function automatic logic [3:0] split_ones(input logic [6:0] value);
    return 4'(value % 7'd10);
  endfunction

endpackage

// File: rtl/fnd_controller_decoder.sv
// -----------------------------------------------------------------------------
// fnd_decoder
// Combinational digit-code to segment decoder.
//   i_code : 4-bit code; 0..9 = decimal digit, 10 = dash, 11..15 = blank
//   o_seg  : 7-bit active-low segments {g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
module fnd_decoder
  import fnd_controller_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // NOTE: every output of a combinational block gets a default before the
  // case, so no code path leaves it unassigned and infers a latch.
  always_comb begin
    o_seg = FONT_BLANK[6:0];
    case (i_code)
      4'd0:      o_seg = FONT_0[6:0];
      4'd1:      o_seg = FONT_1[6:0];
      4'd2:      o_seg = FONT_2[6:0];
      4'd3:      o_seg = FONT_3[6:0];
      4'd4:      o_seg = FONT_4[6:0];
      4'd5:      o_seg = FONT_5[6:0];
      4'd6:      o_seg = FONT_6[6:0];
      4'd7:      o_seg = FONT_7[6:0];
      4'd8:      o_seg = FONT_8[6:0];
      4'd9:      o_seg = FONT_9[6:0];
      CODE_DASH: o_seg = FONT_DASH[6:0];
      default:   o_seg = FONT_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_controller.sv
// -----------------------------------------------------------------------------
// fnd_controller
// Multiplexed driver for a 4-digit common-anode seven-segment display showing
// either sec:msec (mode 0) or hour:min (mode 1) from a stopwatch datapath.
//   clk      : system clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   msec     : hundredths 0..99 (values > 99 render as dashes)
//   sec      : seconds 0..59
//   min      : minutes 0..59
//   hour     : hours 0..23
//   mode     : 0 = sec:msec, 1 = hour:min
//   blank    : 1 = all digits dark from the next clock
//   fnd_comm : active-low one-hot digit enables, bit 0 = rightmost digit
//   fnd_font : active-low segments, bit 7 = dp, bits 6..0 = g..a
// -----------------------------------------------------------------------------
module fnd_controller
  import fnd_controller_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] msec,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [6:0] hour,
  input  logic       mode,
  input  logic       blank,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font
);

  localparam int unsigned SCAN_DIV = scan_div(CLK_HZ, SCAN_HZ);
  localparam int          CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_digit_sel;
  frame_t           r_shadow;

  logic             w_scan_tick;
  logic             w_frame_wrap;
  frame_t           w_live;
  logic [6:0]       w_value;
  logic             w_take_tens;
  logic [3:0]       w_code;
  logic [6:0]       w_seg;
  logic             w_dp_n;

  assign w_scan_tick  = (r_scan_cnt == CNT_LAST);
  // The frame boundary is the step that takes digit 3 back to digit 0.
  assign w_frame_wrap = w_scan_tick && (r_digit_sel == 2'd3);

  assign w_live = '{msec: msec, sec: sec, min: min, hour: hour, mode: mode};

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt <= '0;
    end else if (w_scan_tick) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // The 2-bit selector wraps 3 -> 0 by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_sel <= 2'd0;
    end else if (w_scan_tick) begin
      r_digit_sel <= r_digit_sel + 2'd1;
    end
  end

  // NOTE: the shadow frame is reset even though it is refreshed every frame,
  // because the first frame after reset must show zeros, not stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_frame_wrap) begin
      r_shadow <= w_live;
    end
  end

  // Digit 3/2 carry the left field, digits 1/0 the right field; odd digits
  // take the tens, even digits the ones.
  always_comb begin
    w_value     = 7'd0;
    w_take_tens = 1'b0;
    case (r_digit_sel)
      2'd3: begin
        w_value     = r_shadow.mode ? r_shadow.hour : r_shadow.sec;
        w_take_tens = 1'b1;
      end
      2'd2: begin
        w_value     = r_shadow.mode ? r_shadow.hour : r_shadow.sec;
        w_take_tens = 1'b0;
      end
      2'd1: begin
        w_value     = r_shadow.mode ? r_shadow.min : r_shadow.msec;
        w_take_tens = 1'b1;
      end
      default: begin
        w_value     = r_shadow.mode ? r_shadow.min : r_shadow.msec;
        w_take_tens = 1'b0;
      end
    endcase

    if (w_value > MAX_SHOWN) begin
      w_code = CODE_DASH;
    end else if (w_take_tens) begin
      w_code = split_tens(w_value);
    end else begin
      w_code = split_ones(w_value);
    end

    // dp sits between seconds and hundredths and blinks with the half-second.
    w_dp_n = !((r_digit_sel == 2'd2) && (r_shadow.msec < DP_LIMIT));
  end

  fnd_decoder u_decoder (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Outputs are registered so the pins never glitch while the mux settles;
  // they follow digit_sel by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fnd_comm <= 4'b1111;
      fnd_font <= FONT_BLANK;
    end else if (blank) begin
      fnd_comm <= 4'b1111;
      fnd_font <= FONT_BLANK;
    end else begin
      fnd_comm <= ~(4'b0001 << r_digit_sel);
      fnd_font <= {w_dp_n, w_seg};
    end
  end

endmodule

// File: tb/tb_fnd_controller.sv
// -----------------------------------------------------------------------------
// tb_fnd_controller
// Self-checking bench for fnd_controller with CLK_HZ = 1000, SCAN_HZ = 100
// (10 clocks per digit, 40 clocks per frame). The reference model works in
// terms of clock edges since reset release: edge k shows digit ((k-1)/10)%4,
// and the frame is sampled at every edge k that is a multiple of 40.
// -----------------------------------------------------------------------------
module tb_fnd_controller;

  localparam int STEP_CLKS  = 10;
  localparam int FRAME_CLKS = 40;
  localparam logic [7:0] FONT_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk;
  logic       reset_n;
  logic [6:0] msec, sec, min, hour;
  logic       mode;
  logic       blank;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  int k;                       // edges since reset release
  int sh_msec, sh_sec, sh_min, sh_hour, sh_mode;
  logic [7:0] cap [4];         // last font seen on each digit
  int blank_seen;

  fnd_controller #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .mode     (mode),
    .blank    (blank),
    .fnd_comm (fnd_comm),
    .fnd_font (fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Font expected on digit d from the shadow values, by the display rules.
  function automatic logic [7:0] model_font(input int d);
    int v;
    logic [7:0] f;
    if (d >= 2) v = (sh_mode != 0) ? sh_hour : sh_sec;
    else        v = (sh_mode != 0) ? sh_min  : sh_msec;
    if (v > 99)          f = 8'hBF;
    else if (d % 2 == 1) f = FONT_TBL[v / 10];
    else                 f = FONT_TBL[v % 10];
    if (d == 2 && sh_msec < 50) f[7] = 1'b0;
    return f;
  endfunction

  task automatic clear_model();
    k = 0;
    sh_msec = 0; sh_sec = 0; sh_min = 0; sh_hour = 0; sh_mode = 0;
  endtask

  // One clock edge: predict, sample #1 later, compare.
  task automatic step();
    logic [3:0] exp_comm;
    logic [7:0] exp_font;
    int d;
    @(posedge clk);
    k++;
    d = ((k - 1) / STEP_CLKS) % 4;
    if (blank) begin
      exp_comm = 4'b1111;
      exp_font = 8'hFF;
    end else begin
      exp_comm = ~(4'b0001 << d);
      exp_font = model_font(d);
    end
    if (k % FRAME_CLKS == 0) begin
      sh_msec = int'(msec); sh_sec = int'(sec); sh_min = int'(min);
      sh_hour = int'(hour); sh_mode = int'(mode);
    end
    #1;
    check("comm", {28'b0, fnd_comm}, {28'b0, exp_comm});
    check("font", {24'b0, fnd_font}, {24'b0, exp_font});
    if (fnd_comm == 4'b1111) blank_seen++;
    else cap[d] = fnd_font;
  endtask

  task automatic run_to_latch();
    do step(); while (k % FRAME_CLKS != 0);
  endtask

  task automatic run_frame();
    repeat (FRAME_CLKS) step();
  endtask

  task automatic check_cap(input string tag, input logic [7:0] d3,
                           input logic [7:0] d2, input logic [7:0] d1,
                           input logic [7:0] d0);
    check({tag, "_d3"}, {24'b0, cap[3]}, {24'b0, d3});
    check({tag, "_d2"}, {24'b0, cap[2]}, {24'b0, d2});
    check({tag, "_d1"}, {24'b0, cap[1]}, {24'b0, d1});
    check({tag, "_d0"}, {24'b0, cap[0]}, {24'b0, d0});
  endtask

  initial begin
    reset_n = 1'b0;
    msec = '0; sec = '0; min = '0; hour = '0; mode = 1'b0; blank = 1'b0;
    blank_seen = 0;
    clear_model();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_comm", {28'b0, fnd_comm}, 32'hF);
    check("rst_font", {24'b0, fnd_font}, 32'hFF);

    // First frame with all-zero inputs.
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("first_comm", {28'b0, fnd_comm}, 32'hE);
    check("first_font", {24'b0, fnd_font}, 32'hC0);
    repeat (FRAME_CLKS - 1) step();
    check_cap("zero", 8'hC0, 8'h40, 8'hC0, 8'hC0);

    // sec:msec = 42:75.
    sec = 7'd42; msec = 7'd75; mode = 1'b0;
    run_to_latch();
    run_frame();
    check_cap("s42m75", 8'h99, 8'hA4, 8'hF8, 8'h92);

    // hour:min = 23:05 with msec 10 lighting dp.
    hour = 7'd23; min = 7'd5; msec = 7'd10; mode = 1'b1;
    run_to_latch();
    run_frame();
    check_cap("h23m05", 8'hA4, 8'h30, 8'hC0, 8'h92);

    // Out-of-range msec, then a mid-frame change that must wait a frame.
    mode = 1'b0; sec = 7'd7; msec = 7'd120;
    run_to_latch();
    repeat (5) step();
    msec = 7'd30;
    repeat (FRAME_CLKS - 5) step();
    check_cap("dash", 8'hC0, 8'hF8, 8'hBF, 8'hBF);
    run_frame();
    check_cap("msec30", 8'hC0, 8'h78, 8'hB0, 8'hC0);

    // Three-clock blank pulse in the middle of digit 1.
    while (k % FRAME_CLKS != 13) step();
    blank_seen = 0;
    blank = 1'b1;
    repeat (3) step();
    blank = 1'b0;
    repeat (30) step();
    check("blank_len", blank_seen, 32'd3);

    // Reset in the middle of digit 2.
    sec = 7'd59; min = 7'd44; hour = 7'd12; msec = 7'd88;
    while (k % FRAME_CLKS != 25) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_comm", {28'b0, fnd_comm}, 32'hF);
    check("midrst_font", {24'b0, fnd_font}, 32'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_model();
    reset_n = 1'b1;
    step();
    check("rel_comm", {28'b0, fnd_comm}, 32'hE);
    check("rel_font", {24'b0, fnd_font}, 32'hC0);
    repeat (FRAME_CLKS - 1) step();
    check_cap("relzero", 8'hC0, 8'h40, 8'hC0, 8'hC0);

    // Randomized run: inputs and blank change at arbitrary phases.
    repeat (1600) begin
      if ($urandom_range(0, 7) == 0) begin
        msec = 7'($urandom_range(0, 127));
        sec  = 7'($urandom_range(0, 59));
        min  = 7'($urandom_range(0, 59));
        hour = 7'($urandom_range(0, 23));
        mode = 1'($urandom_range(0, 1));
      end
      blank = ($urandom_range(0, 15) == 0);
      step();
    end
    blank = 1'b0;
    repeat (FRAME_CLKS) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
